// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/ALU/fetch hazard bundle between the pipeline stages and the hazard controller.
// Purely structural, with no latency of its own.
// Flow control is level-based: stall holds decode, and fetch_redirect is held until fetch_ack.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [4:0]  mem_rd;
  logic        br_late_enable;
  logic [31:0] br_target;
  logic        fetch_ack;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        stall;
  logic        fetch_redirect;
  logic [31:0] fetch_target;
  logic        br_late_done;

  // Pipeline side: drives stage state and consumes the hazard decisions.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rd, ex_is_load, mem_rd, br_late_enable, br_target, fetch_ack,
    input  fwd_rs_sel, fwd_rt_sel, stall, fetch_redirect, fetch_target, br_late_done
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rd, ex_is_load, mem_rd, br_late_enable, br_target, fetch_ack,
    output fwd_rs_sel, fwd_rt_sel, stall, fetch_redirect, fetch_target, br_late_done
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Operand forwarding select, load-use stall and late-branch redirect handshake for the ALU stage.
// Forwarding/stall are combinational; redirect outputs are registered (request one cycle after enable).
// The redirect request is held until fetch_ack; stall holds decode while a load or redirect is pending.
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT     = 2,
  parameter int REDIRECT_LAT = 1
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int RCW = (REDIRECT_LAT > 1) ? $clog2(REDIRECT_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [LCW-1:0]  ld_cnt;
  logic [RCW-1:0]  wcnt;
  logic            redirect_q;
  logic [31:0]     target_q;
  logic            done_q;
  logic            hz;
  logic [1:0]      rs_sel;
  logic [1:0]      rt_sel;

  // ALU result wins over mem result; loads in ALU are not forwardable yet.
  function automatic logic [1:0] pick_src(input logic [4:0] idx, input logic used,
                                          input logic [4:0] ex_rd, input logic ex_is_load,
                                          input logic [4:0] mem_rd);
    logic [1:0] sel;
    sel = 2'd0;
    if (used && idx != 5'd0) begin
      if (idx == ex_rd && !ex_is_load) sel = 2'd1;
      else if (idx == mem_rd)          sel = 2'd2;
    end
    return sel;
  endfunction

  // Forwarding selects and load-use hazard detection for the instruction in decode.
  always_comb begin
    rs_sel = pick_src(bus.id_rs, bus.id_uses_rs, bus.ex_rd, bus.ex_is_load, bus.mem_rd);
    rt_sel = pick_src(bus.id_rt, bus.id_uses_rt, bus.ex_rd, bus.ex_is_load, bus.mem_rd);
    hz = bus.id_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
         ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
          (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
  end

  // Load-use tail counter: keeps decode stalled until the load data becomes forwardable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= '0;
    end else if (hz && ld_cnt == '0) begin
      ld_cnt <= LCW'(LOAD_LAT - 1);
    end else if (ld_cnt != '0) begin
      ld_cnt <= ld_cnt - 1'b1;
    end
  end

  // Redirect handshake FSM; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.br_late_enable) begin
            target_q   <= bus.br_target;
            redirect_q <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.fetch_ack) begin
            wcnt       <= RCW'(REDIRECT_LAT - 1);
            redirect_q <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational outputs are forced quiet while reset is asserted.
  always_comb begin
    bus.fwd_rs_sel = rst ? 2'd0 : rs_sel;
    bus.fwd_rt_sel = rst ? 2'd0 : rt_sel;
    bus.stall      = !rst && (hz || ld_cnt != '0 || state == S_REQ || state == S_WAIT);
  end

  assign bus.fetch_redirect = redirect_q;
  assign bus.fetch_target   = target_q;
  assign bus.br_late_done   = done_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed literal checks plus randomized traffic against a timestamp model.
// The model is evaluated on each falling edge while inputs are stable.
// Inputs change only in the first half of each cycle.
module tb_pipeline_hazard_ctrl;
  localparam int LL = 2;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.LOAD_LAT(LL), .REDIRECT_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: absolute cycle stamps instead of state machines.
  int       cyc = 0;
  bit       model_ok = 1'b0;
  int       m_ld_end = -100;   // last cycle the load tail still stalls
  bit       m_busy = 1'b0;     // a redirect has been accepted and not yet completed
  int       m_ack = -1;        // cycle fetch_ack was taken (-1 = still requesting)
  logic [31:0] m_target = '0;
  logic     e_hz, e_req, e_wait, e_done, e_stall;
  logic [1:0] e_rs, e_rt;

  function automatic logic [1:0] src(input logic [4:0] idx, input logic used);
    if (!used || idx == 5'd0) return 2'd0;
    if (idx == bus.ex_rd && !bus.ex_is_load) return 2'd1;
    if (idx == bus.mem_rd) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    e_hz   = bus.id_valid && bus.ex_is_load && bus.ex_rd != 0 &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) || (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
    e_req  = m_busy && m_ack < 0;
    e_wait = m_busy && m_ack >= 0 && cyc <= m_ack + RL;
    e_done = m_busy && m_ack >= 0 && cyc == m_ack + RL + 1;
    e_stall = !rst && (e_hz || cyc <= m_ld_end || e_req || e_wait);
    e_rs = rst ? 2'd0 : src(bus.id_rs, bus.id_uses_rs);
    e_rt = rst ? 2'd0 : src(bus.id_rt, bus.id_uses_rt);
    if (model_ok) begin
      chk("m_fwd_rs", 32'(bus.fwd_rs_sel), 32'(e_rs));
      chk("m_fwd_rt", 32'(bus.fwd_rt_sel), 32'(e_rt));
      chk("m_stall", 32'(bus.stall), 32'(e_stall));
      chk("m_redirect", 32'(bus.fetch_redirect), 32'(e_req));
      chk("m_target", bus.fetch_target, m_target);
      chk("m_done", 32'(bus.br_late_done), 32'(e_done));
    end
    if (rst) begin
      m_ld_end = -100;
      m_busy   = 1'b0;
      m_ack    = -1;
      m_target = '0;
      model_ok = 1'b1;
    end else begin
      if (e_hz && cyc > m_ld_end) m_ld_end = cyc + LL - 1;
      if (e_done) begin
        m_busy = 1'b0;
      end else if (!m_busy && bus.br_late_enable) begin
        m_busy   = 1'b1;
        m_ack    = -1;
        m_target = bus.br_target;
      end else if (e_req && bus.fetch_ack) begin
        m_ack = cyc;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic clear_in();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_rd = 0; bus.ex_is_load = 0; bus.mem_rd = 0;
    bus.br_late_enable = 0; bus.br_target = 0; bus.fetch_ack = 0;
  endtask

  task automatic set_load_use();
    bus.id_valid = 1; bus.ex_is_load = 1; bus.ex_rd = 8; bus.id_rt = 8; bus.id_uses_rt = 1;
  endtask

  initial begin
    clear_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    look();
    chk("rst_fwd_rs", 32'(bus.fwd_rs_sel), 0);
    chk("rst_fwd_rt", 32'(bus.fwd_rt_sel), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_redirect", 32'(bus.fetch_redirect), 0);
    chk("rst_target", bus.fetch_target, 0);
    chk("rst_done", 32'(bus.br_late_done), 0);

    // Forwarding priorities.
    tick();
    bus.id_valid = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_uses_rs = 1;
    look(); chk("fwd_alu", 32'(bus.fwd_rs_sel), 1); chk("fwd_alu_stall", 32'(bus.stall), 0);
    bus.mem_rd = 5;
    look(); chk("fwd_alu_beats_mem", 32'(bus.fwd_rs_sel), 1);
    bus.ex_rd = 0;
    look(); chk("fwd_mem", 32'(bus.fwd_rs_sel), 2);
    tick();
    bus.id_rs = 0;
    look(); chk("fwd_r0", 32'(bus.fwd_rs_sel), 0);

    // Load-use stall: exactly LOAD_LAT cycles for a single hazard.
    tick(); clear_in(); set_load_use();
    look(); chk("lu_stall_c0", 32'(bus.stall), 1);
    tick(); bus.ex_is_load = 0; bus.ex_rd = 0;
    look(); chk("lu_stall_c1", 32'(bus.stall), 1);
    tick();
    look(); chk("lu_stall_c2", 32'(bus.stall), 0);
    tick(); set_load_use(); bus.id_uses_rt = 0;
    look(); chk("lu_unused", 32'(bus.stall), 0);
    tick(); clear_in();

    // Redirect with ack three cycles after enable; second enable in REQ ignored.
    tick(); bus.br_late_enable = 1; bus.br_target = 32'h0040_0020;
    look(); chk("rd_t0_req", 32'(bus.fetch_redirect), 0);
    tick(); bus.br_late_enable = 0;
    look(); chk("rd_t1_req", 32'(bus.fetch_redirect), 1);
    chk("rd_t1_tgt", bus.fetch_target, 32'h0040_0020); chk("rd_t1_stall", 32'(bus.stall), 1);
    tick(); bus.br_late_enable = 1; bus.br_target = 32'hdead_beef;
    look(); chk("rd_t2_req", 32'(bus.fetch_redirect), 1);
    tick(); bus.br_late_enable = 0; bus.fetch_ack = 1;
    look(); chk("rd_t3_req", 32'(bus.fetch_redirect), 1); chk("rd_t3_tgt", bus.fetch_target, 32'h0040_0020);
    tick(); bus.fetch_ack = 0;
    look(); chk("rd_t4_req", 32'(bus.fetch_redirect), 0); chk("rd_t4_stall", 32'(bus.stall), 1);
    chk("rd_t4_done", 32'(bus.br_late_done), 0);
    tick();
    look(); chk("rd_t5_done", 32'(bus.br_late_done), 1); chk("rd_t5_stall", 32'(bus.stall), 0);
    tick();
    look(); chk("rd_t6_done", 32'(bus.br_late_done), 0); chk("rd_t6_tgt", bus.fetch_target, 32'h0040_0020);

    // Reset during WAIT aborts the redirect without a done pulse.
    tick(); bus.br_late_enable = 1; bus.br_target = 32'h0000_1234;
    tick(); bus.br_late_enable = 0; bus.fetch_ack = 1;
    tick(); bus.fetch_ack = 0;
    look(); chk("ab_wait_stall", 32'(bus.stall), 1);
    rst = 1;
    tick(); rst = 0;
    look(); chk("ab_redirect", 32'(bus.fetch_redirect), 0); chk("ab_done", 32'(bus.br_late_done), 0);
    chk("ab_target", bus.fetch_target, 0); chk("ab_stall", 32'(bus.stall), 0);
    tick();
    look(); chk("ab_no_pulse", 32'(bus.br_late_done), 0);

    // Load-use overlapping a redirect.
    tick(); set_load_use(); bus.br_late_enable = 1; bus.br_target = 32'h0040_0040;
    look(); chk("ov_t0_stall", 32'(bus.stall), 1);
    tick(); clear_in(); bus.fetch_ack = 1;
    look(); chk("ov_t1_stall", 32'(bus.stall), 1); chk("ov_t1_req", 32'(bus.fetch_redirect), 1);
    tick(); bus.fetch_ack = 0;
    look(); chk("ov_t2_stall", 32'(bus.stall), 1);
    tick();
    look(); chk("ov_t3_done", 32'(bus.br_late_done), 1);
    tick();

    // Randomized traffic; the negedge model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.id_valid       = $urandom_range(0, 3) != 0;
      bus.id_rs          = 5'($urandom_range(0, 3));
      bus.id_rt          = 5'($urandom_range(0, 3));
      bus.id_uses_rs     = $urandom_range(0, 1) != 0;
      bus.id_uses_rt     = $urandom_range(0, 1) != 0;
      bus.ex_rd          = 5'($urandom_range(0, 3));
      bus.ex_is_load     = $urandom_range(0, 3) == 0;
      bus.mem_rd         = 5'($urandom_range(0, 3));
      bus.br_late_enable = $urandom_range(0, 5) == 0;
      bus.br_target      = $urandom;
      bus.fetch_ack      = $urandom_range(0, 2) == 0;
      rst                = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 0;
    clear_in();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
